// File: rtl/inst_line_buffer.sv
// inst_line_buffer
//   Single-line instruction buffer between the fetch stage and the external
//   instruction memory bus. A request that hits the buffered line is answered
//   combinationally. A miss issues one line-aligned burst that refills the line.
//
// Optional feature: define INST_LINE_BUFFER_BYPASS_EN to enable early restart.
//   With it, the requested word is forwarded from mem_rdata in the cycle its
//   beat arrives. Without it, the requester waits for the whole line.
//
// Parameters
//   LINE_WORDS  32-bit words per line (power of two, >= 2)
//
// Ports
//   clk, reset                      clock; asynchronous active-high reset
//   req_addr, req_valid             fetch request (held until req_ready)
//   req_data, req_ready             combinational response
//   invalidate                      one-cycle pulse that discards the line
//   mem_addr, mem_valid, mem_accept burst request handshake
//   mem_rdata, mem_rvalid           returned beats, word 0 first
module inst_line_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic        req_valid,
  output logic [31:0] req_data,
  output logic        req_ready,
  input  logic        invalidate,
  output logic [31:0] mem_addr,
  output logic        mem_valid,
  input  logic        mem_accept,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int OFS   = $clog2(LINE_WORDS);
  localparam int TAG_W = 30 - OFS;
  localparam logic [OFS-1:0] LAST_BEAT = OFS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      line_q [LINE_WORDS];
  logic [TAG_W-1:0] tag_q;
  logic             line_valid;
  logic             pending_inv;
  logic [OFS-1:0]   beat;

  logic [TAG_W-1:0] req_tag;
  logic [OFS-1:0]   word_sel;
  logic             tag_match;
  logic             hit;
  logic             bypass_hit;
  logic             addr_lsb_unused;

  assign req_tag         = req_addr[31:OFS+2];
  assign word_sel        = req_addr[OFS+1:2];
  assign addr_lsb_unused = ^req_addr[1:0];
  assign tag_match       = (tag_q == req_tag);
  assign hit             = line_valid && tag_match;

`ifdef INST_LINE_BUFFER_BYPASS_EN
  // Early restart: the beat carrying the requested word is forwarded as it
  // arrives. line_valid is low during a fill, so the tag is compared directly.
  assign bypass_hit = (state == FILL) && mem_rvalid && (beat == word_sel) && tag_match;
`else
  assign bypass_hit = 1'b0;
`endif

  assign req_ready = req_valid && !invalidate && (((state == IDLE) && hit) || bypass_hit);

  // Data is gated by req_ready, so req_data reads zero whenever no word is served.
  always_comb begin
    req_data = '0;
    if (req_ready) begin
      req_data = bypass_hit ? mem_rdata : line_q[word_sel];
    end
  end

  // Line storage: beats are written only while filling; stray beats are dropped.
  always_ff @(posedge clk) begin
    if ((state == FILL) && mem_rvalid) begin
      line_q[beat] <= mem_rdata;
    end
  end

  // Control: refill sequencing, tag/valid tracking and the burst request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tag_q       <= '0;
      line_valid  <= 1'b0;
      pending_inv <= 1'b0;
      beat        <= '0;
      mem_addr    <= '0;
      mem_valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (invalidate) begin
            line_valid <= 1'b0;
          end else if (req_valid && !hit) begin
            state      <= REQ;
            mem_addr   <= {req_tag, {(OFS+2){1'b0}}};
            tag_q      <= req_tag;
            line_valid <= 1'b0;
            beat       <= '0;
            mem_valid  <= 1'b1;
          end
        end
        REQ: begin
          if (invalidate) begin
            pending_inv <= 1'b1;
          end
          if (mem_accept) begin
            state     <= FILL;
            mem_valid <= 1'b0;
          end
        end
        FILL: begin
          if (invalidate) begin
            pending_inv <= 1'b1;
          end
          if (mem_rvalid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              // An invalidate landing on the last beat also discards the line.
              state       <= IDLE;
              line_valid  <= !(pending_inv || invalidate);
              pending_inv <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_line_buffer.sv
// Testbench for inst_line_buffer: directed fetch sequence with a memory
// responder model and an expected-data queue popped on each req_ready.
module tb_inst_line_buffer;

  localparam int LW = 4;
`ifdef INST_LINE_BUFFER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] req_addr;
  logic        req_valid;
  logic [31:0] req_data;
  logic        req_ready;
  logic        invalidate;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic        mem_accept;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  inst_line_buffer #(.LINE_WORDS(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_addr   (req_addr),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .invalidate (invalidate),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_accept (mem_accept),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  // memory responder model state
  logic        burst_active;
  int          burst_idx;
  logic [31:0] burst_base;
  logic        start_pend;
  logic [31:0] start_base;
  logic        beat_given;
  int          inv_beat;
  logic        inv_used;
  int          acc_wait;
  int          mv_cnt;
  logic [31:0] last_maddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] base;
    logic [31:0] w;
    base = {a[31:4], 4'h0};
    w    = {30'd0, a[3:2]};
    case (base)
      32'h100: return 32'h11 * (w + 32'd1);
      32'h200: return 32'hA0 + w;
      default: return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic int miss_lat(input logic [31:0] a, input int d);
    return BYPASS ? (2 + d + int'(a[3:2])) : (2 + d + LW);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (beat_given) begin
      burst_idx++;
      if (burst_idx == LW) burst_active = 1'b0;
      beat_given = 1'b0;
    end
    if (start_pend) begin
      burst_active = 1'b1;
      burst_idx    = 0;
      burst_base   = start_base;
      start_pend   = 1'b0;
    end
    mem_rvalid = burst_active;
    mem_rdata  = burst_active ? mem_word(burst_base + 32'(4 * burst_idx)) : 32'hDEAD_BEEF;
    invalidate = 1'b0;
    if (inv_beat >= 0 && burst_active && burst_idx == inv_beat && !inv_used) begin
      invalidate = 1'b1;
      inv_used   = 1'b1;
    end
    mem_accept = (acc_wait == 0);
  endtask

  task automatic observe();
    if (mem_valid) begin
      mv_cnt++;
      last_maddr = mem_addr;
      if (mem_accept) begin
        start_pend = 1'b1;
        start_base = mem_addr;
      end else if (acc_wait > 0) begin
        acc_wait--;
      end
    end
    beat_given = mem_rvalid;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    inv_beat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      drive_mem();
      #1;
      observe();
      if (!burst_active && !start_pend && !mem_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr, input int exp_lat, input int exp_mv,
                       input logic [31:0] exp_maddr, input int inv_b, input int rst_b,
                       input int acc_d);
    logic        done;
    logic [31:0] want;
    done     = 1'b0;
    inv_beat = inv_b;
    inv_used = 1'b0;
    acc_wait = acc_d;
    mv_cnt   = 0;
    last_maddr = '0;
    exp_q.push_back(mem_word(addr));
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      req_addr  = addr;
      req_valid = 1'b1;
      drive_mem();
      if (rst_b >= 0 && burst_active && burst_idx == rst_b) begin
        reset = 1'b1;
        mem_rvalid = 1'b0;
        invalidate = 1'b0;
        burst_active = 1'b0;
        beat_given = 1'b0;
        start_pend = 1'b0;
        #1;
        chk("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        return;
      end
      #1;
      observe();
      if (req_ready) begin
        want = exp_q.pop_front();
        chk($sformatf("data_%h", addr), req_data, want);
        chk($sformatf("lat_%h", addr), 32'(cyc), 32'(exp_lat));
        done = 1'b1;
        break;
      end
    end
    chk($sformatf("served_%h", addr), {31'd0, done}, 32'd1);
    chk($sformatf("mv_cycles_%h", addr), 32'(mv_cnt), 32'(exp_mv));
    if (exp_mv > 0) chk($sformatf("mem_addr_%h", addr), last_maddr, exp_maddr);
    drain();
  endtask

  initial begin
    burst_active = 1'b0; burst_idx = 0; burst_base = '0;
    start_pend = 1'b0; start_base = '0; beat_given = 1'b0;
    inv_beat = -1; inv_used = 1'b0; acc_wait = 0; mv_cnt = 0; last_maddr = '0;
    reset = 1'b1; req_addr = 32'h100; req_valid = 1'b1; invalidate = 1'b0;
    mem_accept = 1'b1; mem_rdata = '0; mem_rvalid = 1'b0;

    // reset held with a request pending
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_req_data", req_data, 32'd0);
    reset = 1'b0; req_valid = 1'b0;

    // cold miss, then hits in the refilled line
    fetch(32'h100, miss_lat(32'h100, 0), 1, 32'h100, -1, -1, 0);
    fetch(32'h10C, 0, 0, 32'h0, -1, -1, 0);
    fetch(32'h104, 0, 0, 32'h0, -1, -1, 0);

    // a stray beat in IDLE must not disturb the line
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    fetch(32'h104, 0, 0, 32'h0, -1, -1, 0);

    // miss at 0x208 (early restart on beat 2 when bypass is built in)
    fetch(32'h208, miss_lat(32'h208, 0), 1, 32'h200, -1, -1, 0);
    fetch(32'h20C, 0, 0, 32'h0, -1, -1, 0);

    // invalidate during beat 2 of the 0x300 fill: the line is discarded
    if (BYPASS) begin
      fetch(32'h30C, miss_lat(32'h30C, 0), 1, 32'h300, 2, -1, 0);
      fetch(32'h30C, miss_lat(32'h30C, 0), 1, 32'h300, -1, -1, 0);
    end else begin
      fetch(32'h30C, 2 * miss_lat(32'h30C, 0), 2, 32'h300, 2, -1, 0);
    end

    // invalidate in IDLE after a hit; it also masks req_ready that cycle
    fetch(32'h304, 0, 0, 32'h0, -1, -1, 0);
    @(posedge clk); #1;
    req_addr = 32'h304; req_valid = 1'b1; invalidate = 1'b1;
    #1;
    chk("inv_masks_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; invalidate = 1'b0;
    fetch(32'h304, miss_lat(32'h304, 0), 1, 32'h300, -1, -1, 0);

    // reset after two beats of a fill, then the same line misses again
    fetch(32'h40C, 0, 0, 32'h0, -1, 2, 0);
    fetch(32'h40C, miss_lat(32'h40C, 0), 1, 32'h400, -1, -1, 0);
    fetch(32'h400, 0, 0, 32'h0, -1, -1, 0);

    // memory holds off acceptance for three cycles
    fetch(32'h504, miss_lat(32'h504, 3), 4, 32'h500, -1, -1, 3);
    fetch(32'h508, 0, 0, 32'h0, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_line_buffer.md
# inst_line_buffer

Single-line instruction buffer between the fetch stage's instruction-memory port and the external instruction memory bus. A fetch request that hits the buffered line is answered combinationally in the same cycle. A miss triggers one line-aligned burst read that refills the buffer. It removes the per-instruction memory round trip for sequential code.

## Interface
Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2. OFS = log2(LINE_WORDS).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_addr  in  32  fetch byte address; bits [1:0] ignored
- req_valid  in  1  fetch request; held with stable req_addr until req_ready
- req_data  out  32  instruction word; meaningful only while req_ready=1
- req_ready  out  1  combinational; request served this cycle
- invalidate  in  1  single-cycle pulse; discard buffered line (fence.i)
- mem_addr  out  32  line base address (low OFS+2 bits zero)
- mem_valid  out  1  burst request; held until mem_accept
- mem_accept  in  1  memory takes request when mem_valid && mem_accept at a rising edge
- mem_rdata  in  32  returned beat
- mem_rvalid  in  1  beat valid; exactly LINE_WORDS beats per accepted request, word 0 first, in order

## Operation
- Storage: LINE_WORDS×32 data, tag = addr[31:OFS+2], line_valid, pending_inv.
- hit = line_valid && tag == req_addr[31:OFS+2]. Word select = req_addr[OFS+1:2].
- States:
  - IDLE → REQ when req_valid && !hit && !invalidate. Latch mem_addr = {req_addr[31:OFS+2], 0}, tag ← same, line_valid ← 0, beat counter ← 0.
  - REQ: mem_valid=1. → FILL on mem_accept.
  - FILL: each mem_rvalid writes word[beat], beat+1. On the last beat → IDLE and line_valid ← !pending_inv; pending_inv ← 0.
- Beats arriving in IDLE or REQ are ignored.
- A req_addr change during REQ/FILL does not abort the burst. The fill completes, then the hit check is re-evaluated.
- invalidate:
  - In IDLE: line_valid ← 0.
  - In REQ/FILL: pending_inv ← 1.
  - While invalidate=1, req_ready is forced to 0.
- req_ready = req_valid && !invalidate && ((state==IDLE && hit) || bypass_hit).
  - bypass_hit is 0 unless the macro below is defined.

## Timing
- Reset values: req_ready 0, req_data 0, mem_valid 0, mem_addr 0, state IDLE, line_valid 0, pending_inv 0, beat 0.
- Hit latency: 0 cycles; req_ready and req_data are valid in the same cycle as req_valid.
- Miss, no bypass:
  - Cycle 0: miss detected.
  - mem_valid rises at edge 1 and holds until accepted.
  - req_ready rises in the cycle after the edge that captures the last beat.
  - Zero memory wait gives miss latency LINE_WORDS+2 cycles.
- mem_valid drops at the accepting edge. At most one burst is outstanding.
- Reset mid-burst: all state clears asynchronously. The memory side must be reset in the same window, so no stale beats follow.
- The beat counter wraps modulo LINE_WORDS; the last beat is beat==LINE_WORDS-1.

## Configuration
- INST_LINE_BUFFER_BYPASS_EN defined (early restart):
  - In FILL, bypass_hit = mem_rvalid && beat == word select && tag match.
  - When bypass_hit=1, req_data = mem_rdata in that cycle.
  - The beat is still written to the line.
- Not defined: bypass_hit = 0. The requester waits for the full line.

## Test plan
- Reset held high with req_valid=1, addr 0x100 → req_ready 0, mem_valid 0, mem_addr 0.
- Cold miss, addr 0x100, mem_accept=1 at once, beats 0x11,0x22,0x33,0x44 on consecutive cycles (no bypass):
  - mem_addr 0x100.
  - mem_valid high exactly 1 cycle.
  - req_ready in the cycle after beat 0x44, req_data 0x11.
- After that fill, addr 0x10C → req_ready same cycle, req_data 0x44, mem_valid stays 0.
- With INST_LINE_BUFFER_BYPASS_EN, miss at 0x208, beats 0xA0..0xA3:
  - req_ready high exactly in the cycle of beat 0xA2, req_data 0xA2.
  - A later request to 0x20C hits with data 0xA3.
- invalidate pulse during the beat 2 cycle of a fill at 0x300:
  - Fill completes.
  - req 0x300 misses again; mem_valid reasserts with mem_addr 0x300.
  - invalidate in IDLE after a hit makes the next request to the same line miss.
- reset asserted during FILL after 2 beats → mem_valid 0 immediately; the next request to the same line misses and issues a new burst.
